// File: rtl/io_timer_pkg.sv
// Shared register map and bit positions for the io_timer bus slave.
package io_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AR      = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PRE_LSB = 8;

    localparam int STAT_FLAG = 0;
    localparam int STAT_RUN  = 1;

endpackage

// File: rtl/io_timer_prescaler.sv
// Free-running 0..pre divider; tick marks the cycle in which the divider wraps.
module io_timer_prescaler #(
    parameter int PWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [PWIDTH-1:0] pre,
    output logic              tick
);

    logic [PWIDTH-1:0] cnt_q;
    logic [PWIDTH-1:0] cnt_d;

    assign tick = en && (cnt_q == pre);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PWIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped interval timer on the CPU IO bus: register decode, count/flag state
// and the combinational read multiplexor.
module io_timer
    import io_timer_pkg::*;
#(
    parameter int CWIDTH = 16,
    parameter int PWIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_b,
    input  logic        rnw,
    input  logic [1:0]  a,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        int_b
);

    logic              en_q, en_d;
    logic              ar_q, ar_d;
    logic              ie_q, ie_d;
    logic [PWIDTH-1:0] pre_q, pre_d;
    logic [CWIDTH-1:0] load_q, load_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic              flag_q, flag_d;

    reg_e sel;
    logic wr, wr_ctrl, wr_load, wr_count, wr_status;
    logic en_rise, en_fall;
    logic tick, tick_eff;

    assign sel       = reg_e'(a);
    assign wr        = !cs_b && !rnw;
    assign wr_ctrl   = wr && (sel == REG_CTRL);
    assign wr_load   = wr && (sel == REG_LOAD);
    assign wr_count  = wr && (sel == REG_COUNT);
    assign wr_status = wr && (sel == REG_STATUS);

    assign en_rise = wr_ctrl && !en_q && din[CTRL_EN];
    assign en_fall = wr_ctrl &&  en_q && !din[CTRL_EN];

    // A COUNT write or a disabling CTRL write pre-empts a coincident tick.
    assign tick_eff = tick && !en_fall && !wr_count;

    io_timer_prescaler #(.PWIDTH(PWIDTH)) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (en_q),
        .clr  (en_rise || wr_count),
        .pre  (pre_q),
        .tick (tick)
    );

    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        ie_d    = ie_q;
        pre_d   = pre_q;
        load_d  = load_q;
        count_d = count_q;
        flag_d  = flag_q;

        if (wr_ctrl) begin
            en_d  = din[CTRL_EN];
            ar_d  = din[CTRL_AR];
            ie_d  = din[CTRL_IE];
            pre_d = din[CTRL_PRE_LSB +: PWIDTH];
        end
        if (wr_load) begin
            load_d = din[CWIDTH-1:0];
        end
        if (wr_status && din[STAT_FLAG]) begin
            flag_d = 1'b0;
        end

        // Expiry is evaluated after the clear so a coincident set wins.
        if (tick_eff) begin
            if (count_q == '0) begin
                flag_d = 1'b1;
                if (ar_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q - CWIDTH'(1);
            end
        end

        if (en_rise) begin
            count_d = load_q;
        end
        if (wr_count) begin
            count_d = din[CWIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            pre_q   <= '0;
            load_q  <= '0;
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            pre_q   <= pre_d;
            load_q  <= load_d;
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        dout = '0;
        case (sel)
            REG_CTRL: begin
                dout[CTRL_EN]                   = en_q;
                dout[CTRL_AR]                   = ar_q;
                dout[CTRL_IE]                   = ie_q;
                dout[CTRL_PRE_LSB +: PWIDTH]    = pre_q;
            end
            REG_LOAD:   dout[CWIDTH-1:0] = load_q;
            REG_COUNT:  dout[CWIDTH-1:0] = count_q;
            REG_STATUS: begin
                dout[STAT_FLAG] = flag_q;
                dout[STAT_RUN]  = en_q;
            end
            default: dout = '0;
        endcase
    end

    assign int_b = !(flag_q && ie_q);

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios with literal expectations,
// then randomized bus traffic compared every cycle against a behavioural model.
module tb_io_timer;

    logic        clk;
    logic        reset;
    logic        cs_b;
    logic        rnw;
    logic [1:0]  a;
    logic [15:0] din;
    logic [15:0] dout;
    logic        int_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    io_timer dut (
        .clk  (clk),
        .reset(reset),
        .cs_b (cs_b),
        .rnw  (rnw),
        .a    (a),
        .din  (din),
        .dout (dout),
        .int_b(int_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents as plain variables, updated by the
    // timer's rules once per rising edge using the values that held before it.
    bit        m_en, m_ar, m_ie, m_flag;
    bit [7:0]  m_pre, m_psc;
    bit [15:0] m_load, m_count;

    task automatic model_edge();
        bit wr, w_ctrl, w_load, w_count, w_stat;
        bit tick, expire;
        bit [15:0] old_load, old_count;
        bit old_en, old_ar;
        wr        = !cs_b && !rnw;
        w_ctrl    = wr && (a == 2'd0);
        w_load    = wr && (a == 2'd1);
        w_count   = wr && (a == 2'd2);
        w_stat    = wr && (a == 2'd3);
        old_load  = m_load;
        old_count = m_count;
        old_en    = m_en;
        old_ar    = m_ar;

        tick = m_en && (m_psc == m_pre);
        if (w_ctrl && m_en && !din[0]) tick = 0;
        if (w_count) tick = 0;

        if ((w_ctrl && din[0] && !old_en) || w_count) m_psc = 8'd0;
        else if (m_en) m_psc = (m_psc == m_pre) ? 8'd0 : m_psc + 8'd1;

        expire = tick && (old_count == 16'd0);
        if (tick) begin
            if (old_count == 16'd0) m_count = old_ar ? old_load : 16'd0;
            else                    m_count = old_count - 16'd1;
        end
        if (w_ctrl) begin
            m_en  = din[0];
            m_ar  = din[1];
            m_ie  = din[2];
            m_pre = din[15:8];
            if (din[0] && !old_en) m_count = old_load;
        end
        if (expire && !old_ar) m_en = 0;
        if (w_load)  m_load  = din;
        if (w_count) m_count = din;
        if (w_stat && din[0]) m_flag = 0;
        if (expire) m_flag = 1;
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] ad);
        case (ad)
            2'd0:    return {m_pre, 5'd0, m_ie, m_ar, m_en};
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return {14'd0, m_en, m_flag};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_flag = 0;
            m_pre = 0; m_psc = 0; m_load = 0; m_count = 0;
        end else begin
            model_edge();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("int_b vs model", {15'd0, int_b}, {15'd0, !(m_flag && m_ie)});
            if (!cs_b) check("dout vs model", dout, model_read(a));
        end
    end

    // Bus helpers: each call starts just after a rising edge and ends just after the next.
    task automatic wr(input logic [1:0] ad, input logic [15:0] d);
        cs_b = 1'b0; rnw = 1'b0; a = ad; din = d;
        @(posedge clk); #1;
        cs_b = 1'b1; rnw = 1'b1;
    endtask

    task automatic rd(input logic [1:0] ad, output logic [15:0] d, output logic ib);
        cs_b = 1'b0; rnw = 1'b1; a = ad; din = $urandom;
        @(negedge clk);
        d  = dout;
        ib = int_b;
        @(posedge clk); #1;
        cs_b = 1'b1;
    endtask

    task automatic idle(input int n);
        cs_b = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    logic [15:0] v;
    logic        ib;
    logic [15:0] seq_exp [5] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd3};

    initial begin
        reset = 1'b1; cs_b = 1'b1; rnw = 1'b1; a = 2'd0; din = 16'd0;
        @(posedge clk); #1;
        cmp_en = 1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        rd(2'd0, v, ib); check("reset CTRL", v, 16'h0000); check("reset int_b", {15'd0, ib}, 16'd1);
        rd(2'd1, v, ib); check("reset LOAD", v, 16'h0000);
        rd(2'd2, v, ib); check("reset COUNT", v, 16'h0000);
        rd(2'd3, v, ib); check("reset STATUS", v, 16'h0000);

        // Auto-reload, PRE=0, period 4
        wr(2'd1, 16'd3);
        wr(2'd0, 16'h0007);
        for (int k = 0; k < 5; k++) begin
            rd(2'd2, v, ib);
            check($sformatf("AR COUNT[%0d]", k), v, seq_exp[k]);
            check($sformatf("AR int_b[%0d]", k), {15'd0, ib}, (k == 4) ? 16'd0 : 16'd1);
        end
        rd(2'd3, v, ib); check("AR STATUS after expiry", v, 16'h0003);
        wr(2'd3, 16'h0001);
        rd(2'd3, v, ib); check("W1C STATUS", v, 16'h0002); check("W1C int_b", {15'd0, ib}, 16'd1);
        idle(3);
        wr(2'd3, 16'h0001);
        rd(2'd3, v, ib); check("W1C on expiry STATUS", v, 16'h0003);
        check("W1C on expiry int_b", {15'd0, ib}, 16'd0);

        // One-shot, LOAD=2, PRE=4: expiry 15 cycles after enable
        wr(2'd0, 16'h0000);
        wr(2'd3, 16'h0001);
        wr(2'd1, 16'd2);
        wr(2'd0, 16'h0401);
        idle(14);
        rd(2'd3, v, ib); check("one-shot before expiry", v, 16'h0002);
        rd(2'd3, v, ib); check("one-shot STATUS", v, 16'h0001);
        rd(2'd2, v, ib); check("one-shot COUNT", v, 16'h0000);
        rd(2'd0, v, ib); check("one-shot CTRL", v, 16'h0400);

        // COUNT write on a tick cycle, then LOAD change mid-count
        wr(2'd1, 16'h0100);
        wr(2'd0, 16'h0303);
        idle(3);
        wr(2'd2, 16'h0005);
        rd(2'd2, v, ib); check("COUNT write wins over tick", v, 16'h0005);
        wr(2'd1, 16'h0010);
        idle(21);
        rd(2'd2, v, ib); check("COUNT before reload", v, 16'h0000);
        rd(2'd2, v, ib); check("COUNT reload new LOAD", v, 16'h0010);

        // Reset mid-count with IE set
        wr(2'd0, 16'h0000);
        wr(2'd3, 16'h0001);
        wr(2'd1, 16'h0001);
        wr(2'd0, 16'h0005);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rd(2'd0, v, ib); check("mid reset CTRL", v, 16'h0000); check("mid reset int_b", {15'd0, ib}, 16'd1);
        rd(2'd1, v, ib); check("mid reset LOAD", v, 16'h0000);
        rd(2'd2, v, ib); check("mid reset COUNT", v, 16'h0000);
        idle(5);
        rd(2'd3, v, ib); check("mid reset STATUS", v, 16'h0000); check("mid reset int_b late", {15'd0, ib}, 16'd1);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            cs_b  = ($urandom_range(0, 9) >= 3);
            rnw   = ($urandom_range(0, 9) >= 4);
            a     = 2'($urandom);
            case (a)
                2'd0: begin
                    din[15:8] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
                    din[7:1]  = 7'($urandom);
                    din[0]    = ($urandom_range(0, 3) != 0);
                end
                2'd1, 2'd2: din = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                default:    din = 16'($urandom);
            endcase
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
